// File: rtl/capture_pkg.sv
// Shared types and constants for the ADC event-capture controller.
package capture_pkg;

    localparam int DWIDTH        = 14;
    localparam int DEFAULT_DEPTH = 16;

    typedef logic [DWIDTH-1:0] sample_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WAIT_TRIG,
        POST,
        READOUT
    } state_t;

endpackage

// File: rtl/capture_ctrl_if.sv
// Readout stream from the capture controller to the pulse-analysis consumer.
interface capture_ctrl_if;
    import capture_pkg::*;

    sample_t data;
    logic    valid;
    logic    ready;
    logic    last;

    modport master (output data, valid, last, input ready);
    modport slave  (input data, valid, last, output ready);

endinterface

// File: rtl/capture_ring.sv
// Simple dual-port sample ring: one write port, one registered read port.
module capture_ring
    import capture_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  sample_t              wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output sample_t              rdata
);

    sample_t mem [DEPTH];

    // NOTE: storage and read register carry no reset so the array maps onto block RAM;
    // consumers only look at rdata after a read they issued themselves.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Pre/post-trigger capture of ADC samples into a ring, then oldest-first readout.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  sample_t              threshold,
    input  logic [ADDR_BITS-1:0] pre_count,
    input  logic [ADDR_BITS-1:0] post_count,
    input  sample_t              sample_in,
    input  logic                 sample_valid,
    capture_ctrl_if.master       stream,
    output logic                 busy,
    output logic                 triggered,
    output logic                 overrun
);

    localparam int CW = ADDR_BITS + 1;
    typedef logic [CW-1:0]        cnt_t;
    typedef logic [ADDR_BITS-1:0] addr_t;

    localparam cnt_t  DEPTH_C  = cnt_t'(DEPTH);
    localparam cnt_t  CNT_ONE  = cnt_t'(1);
    localparam addr_t ADDR_ONE = addr_t'(1);

    state_t  state;
    addr_t   wr_ptr;
    addr_t   rd_ptr;
    sample_t thr_q;
    sample_t prev_sample;
    cnt_t    pre_q;
    cnt_t    post_q;
    cnt_t    cnt_q;
    cnt_t    issue_left;
    cnt_t    load_left;
    logic    ring_vld;
    sample_t ring_q;

    cnt_t post_raw;
    cnt_t post_eff;
    cnt_t win_sum;

    // Post count is at least 1 (the trigger sample) and the window never exceeds the ring.
    always_comb begin
        post_raw = (post_count == '0) ? CNT_ONE : {1'b0, post_count};
        win_sum  = {1'b0, pre_count} + post_raw;
        post_eff = post_raw;
        if (win_sum > DEPTH_C) begin
            post_eff = DEPTH_C - {1'b0, pre_count};
        end
    end

    logic write_en;
    logic crossing;
    logic move;
    logic issue;
    logic accept_last;

    assign write_en    = sample_valid && (state == FILL || state == WAIT_TRIG || state == POST);
    assign crossing    = (state == WAIT_TRIG) && sample_valid &&
                         (sample_in > thr_q) && (prev_sample <= thr_q);
    // The ring read register doubles as the one-entry prefetch behind the output register.
    assign move        = ring_vld && (!stream.valid || stream.ready);
    assign issue       = (state == READOUT) && (issue_left != '0) && (!ring_vld || move);
    assign accept_last = stream.valid && stream.ready && stream.last;

    capture_ring #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_ring (
        .clk   (clk),
        .we    (write_en),
        .waddr (wr_ptr),
        .wdata (sample_in),
        .re    (issue),
        .raddr (rd_ptr),
        .rdata (ring_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            thr_q        <= '0;
            prev_sample  <= '0;
            pre_q        <= '0;
            post_q       <= '0;
            cnt_q        <= '0;
            issue_left   <= '0;
            load_left    <= '0;
            ring_vld     <= 1'b0;
            stream.data  <= '0;
            stream.valid <= 1'b0;
            stream.last  <= 1'b0;
            busy         <= 1'b0;
            triggered    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            triggered <= 1'b0;

            if (write_en) begin
                wr_ptr      <= wr_ptr + ADDR_ONE;
                prev_sample <= sample_in;
            end

            if (issue) begin
                rd_ptr     <= rd_ptr + ADDR_ONE;
                issue_left <= issue_left - CNT_ONE;
                ring_vld   <= 1'b1;
            end else if (move) begin
                ring_vld <= 1'b0;
            end

            if (move) begin
                stream.data  <= ring_q;
                stream.valid <= 1'b1;
                stream.last  <= (load_left == CNT_ONE);
                load_left    <= load_left - CNT_ONE;
            end else if (stream.valid && stream.ready) begin
                stream.valid <= 1'b0;
                stream.last  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (arm) begin
                        thr_q       <= threshold;
                        pre_q       <= {1'b0, pre_count};
                        post_q      <= post_eff;
                        prev_sample <= '1;
                        overrun     <= 1'b0;
                        cnt_q       <= '0;
                        busy        <= 1'b1;
                        state       <= (pre_count == '0) ? WAIT_TRIG : FILL;
                    end
                end
                FILL: begin
                    if (sample_valid) begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q + CNT_ONE == pre_q) begin
                            state <= WAIT_TRIG;
                        end
                    end
                end
                WAIT_TRIG: begin
                    if (crossing) begin
                        triggered  <= 1'b1;
                        rd_ptr     <= wr_ptr - pre_q[ADDR_BITS-1:0];
                        issue_left <= pre_q + post_q;
                        load_left  <= pre_q + post_q;
                        cnt_q      <= CNT_ONE;
                        state      <= (post_q == CNT_ONE) ? READOUT : POST;
                    end
                end
                POST: begin
                    if (sample_valid) begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q + CNT_ONE == post_q) begin
                            state <= READOUT;
                        end
                    end
                end
                READOUT: begin
                    if (sample_valid) begin
                        overrun <= 1'b1;
                    end
                    if (accept_last) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: vector table plus hand-written capture sequences.
module tb_capture_ctrl;
    import capture_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          arm = 1'b0;
    sample_t       threshold = '0;
    logic [3:0]    pre_count = '0;
    logic [3:0]    post_count = '0;
    sample_t       sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          busy;
    logic          triggered;
    logic          overrun;

    capture_ctrl_if stream();

    capture_ctrl #(.DEPTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .threshold    (threshold),
        .pre_count    (pre_count),
        .post_count   (post_count),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .stream       (stream),
        .busy         (busy),
        .triggered    (triggered),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    sample_t exp_q[$];

    typedef struct {
        logic       arm;
        logic [3:0] pre;
        logic [3:0] post;
        sample_t    thr;
        logic       sv;
        sample_t    smp;
        logic       rdy;
        logic       e_trig;
        logic       e_valid;
        sample_t    e_data;
        logic       e_last;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int a, int pr, int po, int th, int sv, int smp, int rdy,
                                int et, int ev, int ed, int el, int eb);
        vec_t v;
        v.arm = a[0];       v.pre = pr[3:0];       v.post = po[3:0];
        v.thr = th[13:0];   v.sv = sv[0];          v.smp = smp[13:0];
        v.rdy = rdy[0];     v.e_trig = et[0];      v.e_valid = ev[0];
        v.e_data = ed[13:0]; v.e_last = el[0];     v.e_busy = eb[0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int pr, input int po, input int th);
        arm = 1'b1;
        pre_count = pr[3:0];
        post_count = po[3:0];
        threshold = th[13:0];
        tick();
        arm = 1'b0;
        check("arm busy", busy, 1);
    endtask

    task automatic send(input int s, input logic exp_trig, input string tag);
        sample_in = s[13:0];
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check({tag, " trig"}, triggered, exp_trig);
    endtask

    // Drains exp_q from the stream; ready follows pat[cycle % 4].
    task automatic collect(input logic [3:0] pat, input string tag);
        int idx;
        int cyc;
        logic was_held;
        idx = 0;
        cyc = 0;
        was_held = 1'b0;
        while (idx < exp_q.size() && cyc < 300) begin
            stream.ready = pat[cyc % 4];
            if (was_held) check({tag, " held valid"}, stream.valid, 1);
            was_held = 1'b0;
            if (stream.valid) begin
                check($sformatf("%s data[%0d]", tag, idx), stream.data, exp_q[idx]);
                check($sformatf("%s last[%0d]", tag, idx), stream.last, (idx == exp_q.size() - 1));
                if (stream.ready) idx++;
                else was_held = 1'b1;
            end
            tick();
            cyc++;
        end
        check({tag, " count"}, idx, exp_q.size());
        check({tag, " done valid"}, stream.valid, 0);
        check({tag, " done busy"}, busy, 0);
        stream.ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        stream.ready = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("reset busy", busy, 0);
        check("reset valid", stream.valid, 0);
        check("reset last", stream.last, 0);
        check("reset data", stream.data, 0);
        check("reset trig", triggered, 0);
        check("reset overrun", overrun, 0);
        rst_n = 1'b1;
        tick();

        // Reset while in POST abandons the capture.
        do_arm(1, 4, 5);
        send(1, 1'b0, "rp fill");
        send(10, 1'b1, "rp cross");
        send(11, 1'b0, "rp post");
        check("rp busy before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rp busy", busy, 0);
        check("rp valid", stream.valid, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // PRE=2 POST=2 THR=100, ARM ignored while busy; then PRE=0 POST=0 THR=50.
        vecs.push_back(mk(1, 2, 2, 100, 0,   0, 1, 0, 0,   0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   0, 1,  10, 1, 0, 0,   0, 0, 1));
        vecs.push_back(mk(1, 0, 0,   0, 1,  20, 1, 0, 0,   0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   0, 1,  30, 1, 0, 0,   0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   0, 1, 150, 1, 1, 0,   0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   0, 1, 160, 1, 0, 0,   0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   0, 0,   0, 1, 0, 0,   0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   0, 0,   0, 1, 0, 1,  20, 0, 1));
        vecs.push_back(mk(0, 0, 0,   0, 0,   0, 1, 0, 1,  30, 0, 1));
        vecs.push_back(mk(0, 0, 0,   0, 0,   0, 1, 0, 1, 150, 0, 1));
        vecs.push_back(mk(0, 0, 0,   0, 0,   0, 1, 0, 1, 160, 1, 1));
        vecs.push_back(mk(0, 0, 0,   0, 0,   0, 1, 0, 0,   0, 0, 0));
        vecs.push_back(mk(1, 0, 0,  50, 0,   0, 1, 0, 0,   0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   0, 1,  60, 1, 0, 0,   0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   0, 1,  40, 1, 0, 0,   0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   0, 1,  70, 1, 1, 0,   0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   0, 0,   0, 1, 0, 0,   0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   0, 0,   0, 1, 0, 1,  70, 1, 1));
        vecs.push_back(mk(1, 0, 0,   0, 0,   0, 1, 0, 0,   0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0, 0,   0, 1, 0, 0,   0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            arm = vecs[i].arm;
            pre_count = vecs[i].pre;
            post_count = vecs[i].post;
            threshold = vecs[i].thr;
            sample_valid = vecs[i].sv;
            sample_in = vecs[i].smp;
            stream.ready = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d trig", i), triggered, vecs[i].e_trig);
            check($sformatf("vec%0d valid", i), stream.valid, vecs[i].e_valid);
            check($sformatf("vec%0d last", i), stream.last, vecs[i].e_last);
            check($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
            if (vecs[i].e_valid) check($sformatf("vec%0d data", i), stream.data, vecs[i].e_data);
        end
        arm = 1'b0;
        sample_valid = 1'b0;

        // Samples arriving during readout are dropped and flag overrun.
        do_arm(1, 2, 100);
        send(10, 1'b0, "ov fill");
        send(150, 1'b1, "ov cross");
        send(160, 1'b0, "ov post");
        stream.ready = 1'b0;
        sample_in = 7;
        sample_valid = 1'b1;
        tick();
        tick();
        sample_valid = 1'b0;
        check("ov set", overrun, 1);
        exp_q = '{10, 150, 160};
        collect(4'b1111, "ov");
        check("ov sticky", overrun, 1);
        do_arm(1, 1, 100);
        check("ov cleared", overrun, 0);

        // Reset while a readout sample is presented.
        send(10, 1'b0, "rr fill");
        send(150, 1'b1, "rr cross");
        stream.ready = 1'b0;
        tick();
        tick();
        tick();
        check("rr valid before", stream.valid, 1);
        check("rr data before", stream.data, 10);
        #2 rst_n = 1'b0;
        #1;
        check("rr valid", stream.valid, 0);
        check("rr busy", busy, 0);
        check("rr data", stream.data, 0);
        tick();
        rst_n = 1'b1;
        stream.ready = 1'b1;
        tick();

        // Clamped window (10 + 6) wrapping 15->0, drained with ready 1,0,0,1.
        do_arm(10, 10, 100);
        for (int k = 1; k <= 10; k++) send(k, 1'b0, "wr fill");
        send(50, 1'b0, "wr wait0");
        send(50, 1'b0, "wr wait1");
        send(50, 1'b0, "wr wait2");
        send(200, 1'b1, "wr cross");
        for (int k = 201; k <= 205; k++) send(k, 1'b0, "wr post");
        exp_q = '{4, 5, 6, 7, 8, 9, 10, 50, 50, 50, 200, 201, 202, 203, 204, 205};
        collect(4'b1001, "wrap");

        // Crossing during FILL is ignored; later crossing in WAIT_TRIG fires.
        do_arm(4, 1, 100);
        send(10, 1'b0, "fx fill0");
        send(200, 1'b0, "fx fill1");
        send(30, 1'b0, "fx fill2");
        send(40, 1'b0, "fx fill3");
        send(50, 1'b0, "fx wait");
        send(120, 1'b1, "fx cross");
        exp_q = '{200, 30, 40, 50, 120};
        collect(4'b1111, "fx");

        do_reset();
        check("final busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Event-capture controller for the HSMC ADC sample path of the cytometer.
- Keeps a rolling pre-trigger history of ADC samples in a circular sample ring and watches for a rising threshold crossing.
- On a crossing it captures a programmable number of post-trigger samples, then streams the PRE+POST window, oldest first, to a downstream consumer over a valid/ready handshake.
- Sits between the ADC sample register and the pulse-analysis / readout logic.

Parameters:
- DWIDTH, 14: sample width in bits, unsigned.
- DEPTH, 16: ring depth in samples; must be a power of two ≥ 4.
- ADDR_BITS, $clog2(DEPTH): ring address width.

Ports:
- CLOCK  in  1: single clock domain.
- RESET  in  1: asynchronous, active-low reset.
- ARM  in  1: single-cycle pulse that starts a capture; honoured only in IDLE.
- THRESHOLD  in  DWIDTH: trigger level; latched at ARM.
- PRE_COUNT  in  ADDR_BITS: pre-trigger samples; latched at ARM.
- POST_COUNT  in  ADDR_BITS: post-trigger samples, including the trigger sample; latched at ARM.
- SAMPLE_IN  in  DWIDTH: ADC sample.
- SAMPLE_VALID  in  1: SAMPLE_IN is valid this cycle.
- OUT_DATA  out  DWIDTH: readout sample.
- OUT_VALID  out  1: OUT_DATA is valid.
- OUT_READY  in  1: consumer accepts OUT_DATA.
- OUT_LAST  out  1: marks the final sample of the window.
- BUSY  out  1: high in any state except IDLE.
- TRIGGERED  out  1: one-cycle pulse on the trigger sample.
- OVERRUN  out  1: sticky; cleared by an accepted ARM.

Behaviour:
- Reset values: all outputs 0; state IDLE; write/read pointers 0; latched config 0. Ring contents are not reset.

States:
- IDLE: wait for ARM.
- FILL: store samples until PRE_COUNT have been written.
- WAIT_TRIG: keep storing (ring overwrites); test each sample for a crossing.
- POST: store until the post count is met.
- READOUT: stream the window.
- Return to IDLE after the sample with OUT_LAST is accepted.

Configuration and arming:
- Accepted ARM latches THRESHOLD, PRE_COUNT, POST_COUNT; clears OVERRUN; sets prev_sample to all-ones.
- Next state on ARM: FILL, or WAIT_TRIG if PRE_COUNT = 0.
- POST_COUNT = 0 is treated as 1.
- If PRE+POST > DEPTH, post is clamped to DEPTH − PRE. Width of the sum is ADDR_BITS+1.

Writing:
- Every SAMPLE_VALID in FILL, WAIT_TRIG or POST writes the ring at wr_ptr.
- wr_ptr increments modulo DEPTH (natural wrap).
- prev_sample updates on every such write.

Trigger:
- In WAIT_TRIG only, fires when SAMPLE_VALID and SAMPLE_IN > THRESHOLD and prev_sample ≤ THRESHOLD (unsigned compare).
- The trigger sample is written and counts as post sample 1. TRIGGERED pulses the same cycle.
- Crossings during FILL are ignored. The first sample after ARM never triggers.
- If post = 1, go directly to READOUT.

Window and readout:
- start address = trigger address − PRE (mod DEPTH); length = PRE + post.
- READOUT entry cycle issues the first read.
- Ring read is registered, 1-cycle latency: OUT_VALID rises 2 cycles after the POST→READOUT transition.
- OUT_DATA/OUT_VALID/OUT_LAST hold stable while OUT_VALID & !OUT_READY.
- With OUT_READY held high, one sample per cycle with no bubbles; use a 1-entry skid/prefetch.
- OUT_LAST is high with the final sample only.

Overrun and ARM corner cases:
- SAMPLE_VALID during READOUT: sample is discarded and OVERRUN is set.
- ARM while BUSY is ignored.
- ARM in the same cycle the last sample is accepted is ignored; the block returns to IDLE.

Reset mid-operation:
- Immediate return to IDLE with outputs 0, including during READOUT with OUT_VALID high.
- No partial-window completion.

Decomposition:
- Package capture_pkg holds:
  - state enum: IDLE, FILL, WAIT_TRIG, POST, READOUT
  - ADC sample typedef, DWIDTH = 14
  - default DEPTH constant
- One sub-module, capture_ring: simple dual-port DEPTH×DWIDTH memory with write enable/address and a registered read with read enable.
  - Contains no reset on storage.
  - Pointers and control stay in capture_ctrl.

Test Plan:
- Reset during POST, then release, ARM PRE=2 POST=2 THR=100, samples 10,20,30,150,160 → TRIGGERED on 150; readout 20,30,150,160; OUT_LAST on 160; BUSY falls after its acceptance.
- PRE=0 POST=0, THR=50, samples 60,40,70 → first sample 60 doesn't trigger; 70 triggers; single-sample readout 70 with OUT_LAST.
- PRE=10 POST=10, DEPTH=16 → post clamped to 6; 16 samples read out with wrap across address 15→0, oldest first.
- Readout with OUT_READY toggling 1,0,0,1,… → each sample held stable while not ready; no duplicates or drops; order preserved.
- SAMPLE_VALID pulses during READOUT → OVERRUN=1 and readout data unchanged; next ARM clears OVERRUN.
- Crossing sample 200 during FILL (PRE=4, THR=100) → no trigger; later 50→120 in WAIT_TRIG → triggers on 120.
